vram_arbiter: RTL and testbench

- Shares the single-port video RAM between two requesters:
  - CPU pixel writes, issued by the VGA instruction, pushed into a small write FIFO.
  - VGA scan-out reads, which have a hard deadline.
- Reads always win; buffered writes drain in free cycles.
- A starvation guard forces a write when the CPU has stalled too long.
- Sits between the MiniProcessor execute stage, the VGA timing controller and the video RAM.

---
 rtl/vram_arbiter_pkg.sv | 32 +++
 rtl/vram_arbiter_if.sv | 45 ++++
 rtl/vram_write_fifo.sv | 73 +++++++
 rtl/vram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter: widths, colour codes,
// the {row,col} address packing helper and the arbiter FSM states.
package vram_arbiter_pkg;

    localparam int ADDR_W          = 16;
    localparam int COORD_W         = 8;
    localparam int DEFAULT_COLOR_W = 3;

    // 3-bit RGB colour codes, identical to the processor's COLOR_* values
    localparam logic [2:0] COLOR_BLACK   = 3'b000;
    localparam logic [2:0] COLOR_BLUE    = 3'b001;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_CYAN    = 3'b011;
    localparam logic [2:0] COLOR_RED     = 3'b100;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;
    localparam logic [2:0] COLOR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOR_WHITE   = 3'b111;

    typedef enum logic [0:0] {
        S_NORMAL      = 1'b0,
        S_FORCE_WRITE = 1'b1
    } arbState_e;

    // Video RAM address is the row in the upper byte, column in the lower byte
    function automatic logic [ADDR_W-1:0] packAddr(
        input logic [COORD_W-1:0] row,
        input logic [COORD_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the arbiter and its three neighbours: the CPU write
// port, the VGA scan-out read port and the single-port video RAM.
// The slave modport is the arbiter's view, master is the environment's.
interface vram_arbiter_if
    import vram_arbiter_pkg::*;
#(
    parameter int COLOR_W = DEFAULT_COLOR_W
);

    logic                iCpuWrEn;
    logic [COORD_W-1:0]  iCpuCol;
    logic [COORD_W-1:0]  iCpuRow;
    logic [COLOR_W-1:0]  iCpuColor;
    logic                oCpuStall;

    logic                iVgaRdReq;
    logic [COORD_W-1:0]  iVgaCol;
    logic [COORD_W-1:0]  iVgaRow;
    logic [COLOR_W-1:0]  oVgaData;
    logic                oVgaValid;

    logic [ADDR_W-1:0]   oMemAddr;
    logic                oMemWe;
    logic [COLOR_W-1:0]  oMemWData;
    logic [COLOR_W-1:0]  iMemRData;

    modport slave (
        input  iCpuWrEn, iCpuCol, iCpuRow, iCpuColor,
        output oCpuStall,
        input  iVgaRdReq, iVgaCol, iVgaRow,
        output oVgaData, oVgaValid,
        output oMemAddr, oMemWe, oMemWData,
        input  iMemRData
    );

    modport master (
        output iCpuWrEn, iCpuCol, iCpuRow, iCpuColor,
        input  oCpuStall,
        output iVgaRdReq, iVgaCol, iVgaRow,
        input  oVgaData, oVgaValid,
        input  oMemAddr, oMemWe, oMemWData,
        output iMemRData
    );

endinterface

// File: rtl/vram_write_fifo.sv
// Small synchronous FIFO holding pending CPU pixel writes as packed
// {row,col,color} entries. DEPTH must be a power of two so the pointers
// wrap for free. Push while full and pop while empty are ignored.
module vram_write_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 19
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_W-1:0]            pushData_i,
    output logic [DATA_W-1:0]            headData_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              doPush, doPop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign headData_o = mem[rdPtr_q];
    assign doPush     = push_i && !full_o;
    assign doPop      = pop_i && !empty_o;

    // Advance pointers and occupancy; a simultaneous push and pop keeps the count
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards every pending entry
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset since the count gates every read of it
    always_ff @(posedge Clock) begin
        if (doPush) begin
            mem[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: VGA scan-out reads always win the single RAM port,
// CPU pixel writes are buffered and drain in free cycles. If the CPU sits
// stalled on a full FIFO behind STARVE_LIMIT consecutive reads, one read
// is dropped and the oldest write is forced through.
// Optional build macro VRAM_ARB_STATS_EN adds stall/forced-write counters.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int COLOR_W      = DEFAULT_COLOR_W
) (
    input  logic          Clock,
    input  logic          Reset,
    vram_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]   oStallCycles,
    output logic [7:0]    oForcedWrites
`endif
);

    localparam int ENTRY_W  = 2*COORD_W + COLOR_W;
    localparam int CNT_W    = $clog2(FIFO_DEPTH+1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT+1);

    arbState_e            state_q, state_d;
    logic [STARVE_W-1:0]  starveCnt_q, starveCnt_d;
    logic                 vgaValid_q;

    logic [ENTRY_W-1:0]   pushData, headData;
    logic [CNT_W-1:0]     fifoCount;
    logic                 fifoPush, fifoPop, fifoFull, fifoEmpty;

    logic [COORD_W-1:0]   headRow, headCol;
    logic [COLOR_W-1:0]   headColor;

    logic                 readGrant, writeGrant, starveHit;
    logic [ADDR_W-1:0]    memAddr;
    logic                 memWe;
    logic [COLOR_W-1:0]   memWData;

    assign pushData  = {bus.iCpuRow, bus.iCpuCol, bus.iCpuColor};
    assign headRow   = headData[ENTRY_W-1 -: COORD_W];
    assign headCol   = headData[COLOR_W +: COORD_W];
    assign headColor = headData[COLOR_W-1:0];

    assign fifoPush  = bus.iCpuWrEn && !fifoFull && !Reset;
    assign fifoPop   = writeGrant;

    vram_write_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (ENTRY_W)
    ) uWriteFifo (
        .Clock      (Clock),
        .Reset      (Reset),
        .push_i     (fifoPush),
        .pop_i      (fifoPop),
        .pushData_i (pushData),
        .headData_o (headData),
        .count_o    (fifoCount),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // Grant the RAM port and track starvation; nothing is granted while in reset
    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        readGrant   = 1'b0;
        writeGrant  = 1'b0;
        starveHit   = 1'b0;
        memAddr     = '0;
        memWe       = 1'b0;
        memWData    = '0;
        if (!Reset) begin
            case (state_q)
                S_NORMAL: begin
                    if (bus.iVgaRdReq) begin
                        readGrant = 1'b1;
                        memAddr   = packAddr(bus.iVgaRow, bus.iVgaCol);
                    end else if (!fifoEmpty) begin
                        writeGrant = 1'b1;
                        memAddr    = packAddr(headRow, headCol);
                        memWData   = headColor;
                        memWe      = 1'b1;
                    end
                    starveHit = (fifoCount == CNT_W'(FIFO_DEPTH)) && bus.iCpuWrEn && readGrant;
                    if (starveHit) begin
                        if (starveCnt_q == STARVE_W'(STARVE_LIMIT-1)) begin
                            state_d     = S_FORCE_WRITE;
                            starveCnt_d = '0;
                        end else begin
                            starveCnt_d = starveCnt_q + STARVE_W'(1);
                        end
                    end else begin
                        starveCnt_d = '0;
                    end
                end
                S_FORCE_WRITE: begin
                    if (!fifoEmpty) begin
                        writeGrant = 1'b1;
                        memAddr    = packAddr(headRow, headCol);
                        memWData   = headColor;
                        memWe      = 1'b1;
                    end
                    starveCnt_d = '0;
                    state_d     = S_NORMAL;
                end
                default: begin
                    state_d     = S_NORMAL;
                    starveCnt_d = '0;
                end
            endcase
        end
    end

    // State, starvation counter and the one-cycle read-return flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_NORMAL;
            starveCnt_q <= '0;
            vgaValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            vgaValid_q  <= readGrant;
        end
    end

    assign bus.oCpuStall = fifoFull;
    assign bus.oMemAddr  = memAddr;
    assign bus.oMemWe    = memWe;
    assign bus.oMemWData = memWData;
    assign bus.oVgaValid = vgaValid_q;
    assign bus.oVgaData  = vgaValid_q ? bus.iMemRData : '0;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stallCycles_q;
    logic [7:0]  forcedWrites_q;

    // Saturating counters of CPU stall cycles and forced-write cycles
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stallCycles_q  <= '0;
            forcedWrites_q <= '0;
        end else begin
            if (fifoFull && bus.iCpuWrEn && (stallCycles_q != 16'hFFFF)) begin
                stallCycles_q <= stallCycles_q + 16'd1;
            end
            if ((state_q == S_FORCE_WRITE) && (forcedWrites_q != 8'hFF)) begin
                forcedWrites_q <= forcedWrites_q + 8'd1;
            end
        end
    end

    assign oStallCycles  = stallCycles_q;
    assign oForcedWrites = forcedWrites_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios with fixed
// expectations, then a randomized run compared against a queue-based
// reference model of the arbitration rules. Video RAM is modelled here.
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int CW    = 3;

    typedef struct {
        logic [15:0]   addr;
        logic [CW-1:0] color;
    } wrEntry_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [CW-1:0] envRam [0:65535] = '{default: '0};
    logic [CW-1:0] refRam [0:65535];
    logic [CW-1:0] palette [8];

    vram_arbiter_if #(.COLOR_W(CW)) bus();

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] oStallCycles;
    logic [7:0]  oForcedWrites;
`endif

    vram_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT),
        .COLOR_W      (CW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
`ifdef VRAM_ARB_STATS_EN
        ,
        .oStallCycles  (oStallCycles),
        .oForcedWrites (oForcedWrites)
`endif
    );

    always #5 Clock = ~Clock;

    // Synchronous single-port RAM with one cycle of read latency
    always @(posedge Clock) begin
        if (bus.oMemWe) envRam[bus.oMemAddr] <= bus.oMemWData;
        bus.iMemRData <= envRam[bus.oMemAddr];
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        @(negedge Clock);
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] row, input logic [7:0] col,
                                 input logic [CW-1:0] color, input logic rd,
                                 input logic [7:0] vRow, input logic [7:0] vCol);
        bus.iCpuWrEn  = wr;
        bus.iCpuRow   = row;
        bus.iCpuCol   = col;
        bus.iCpuColor = color;
        bus.iVgaRdReq = rd;
        bus.iVgaRow   = vRow;
        bus.iVgaCol   = vCol;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        settle();
        checks++; if (bus.oCpuStall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %0b expected 0", bus.oCpuStall); end
        checks++; if (bus.oVgaValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.oVgaValid); end
        checks++; if (bus.oVgaData !== 3'b000) begin failures++; $display("[TB] FAIL reset_data: got %0h expected 0", bus.oVgaData); end
        checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %0b expected 0", bus.oMemWe); end
        checks++; if (bus.oMemAddr !== 16'h0000) begin failures++; $display("[TB] FAIL reset_addr: got %0h expected 0", bus.oMemAddr); end
        checks++; if (bus.oMemWData !== 3'b000) begin failures++; $display("[TB] FAIL reset_wdata: got %0h expected 0", bus.oMemWData); end
        nextCycle();
    endtask

    task automatic test_single_write();
        doReset();
        applyStimulus(1, 8'd2, 8'd5, COLOR_GREEN, 0, 0, 0);
        settle();
        checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL sw_push_we: got %0b expected 0", bus.oMemWe); end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (bus.oMemWe !== 1'b1) begin failures++; $display("[TB] FAIL sw_we: got %0b expected 1", bus.oMemWe); end
        checks++; if (bus.oMemAddr !== 16'h0205) begin failures++; $display("[TB] FAIL sw_addr: got %0h expected 0205", bus.oMemAddr); end
        checks++; if (bus.oMemWData !== 3'b010) begin failures++; $display("[TB] FAIL sw_wdata: got %0h expected 2", bus.oMemWData); end
        nextCycle();
        settle();
        checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL sw_empty_we: got %0b expected 0", bus.oMemWe); end
        nextCycle();
    endtask

    task automatic test_read_latency();
        doReset();
        applyStimulus(1, 8'd1, 8'd1, COLOR_RED, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 8'd1, 8'd1);
        settle();
        checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL rd_we: got %0b expected 0", bus.oMemWe); end
        checks++; if (bus.oMemAddr !== 16'h0101) begin failures++; $display("[TB] FAIL rd_addr: got %0h expected 0101", bus.oMemAddr); end
        checks++; if (bus.oVgaValid !== 1'b0) begin failures++; $display("[TB] FAIL rd_early_valid: got %0b expected 0", bus.oVgaValid); end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (bus.oVgaValid !== 1'b1) begin failures++; $display("[TB] FAIL rd_valid: got %0b expected 1", bus.oVgaValid); end
        checks++; if (bus.oVgaData !== 3'b100) begin failures++; $display("[TB] FAIL rd_data: got %0h expected 4", bus.oVgaData); end
        nextCycle();
        settle();
        checks++; if (bus.oVgaValid !== 1'b0) begin failures++; $display("[TB] FAIL rd_late_valid: got %0b expected 0", bus.oVgaValid); end
        checks++; if (bus.oVgaData !== 3'b000) begin failures++; $display("[TB] FAIL rd_late_data: got %0h expected 0", bus.oVgaData); end
        nextCycle();
    endtask

    task automatic test_starvation();
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'h10 + 8'(i), 8'h20 + 8'(i), palette[i+1], 1, 8'd3, 8'd3);
            settle();
            checks++; if (bus.oCpuStall !== 1'b0) begin failures++; $display("[TB] FAIL st_fill_stall%0d: got %0b expected 0", i, bus.oCpuStall); end
            checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL st_fill_we%0d: got %0b expected 0", i, bus.oMemWe); end
            nextCycle();
        end
        applyStimulus(1, 8'h14, 8'h24, palette[5], 1, 8'd3, 8'd3);
        for (int k = 1; k <= LIMIT; k++) begin
            settle();
            checks++; if (bus.oCpuStall !== 1'b1) begin failures++; $display("[TB] FAIL st_block_stall%0d: got %0b expected 1", k, bus.oCpuStall); end
            checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL st_block_we%0d: got %0b expected 0", k, bus.oMemWe); end
            nextCycle();
        end
        settle();
        checks++; if (bus.oMemWe !== 1'b1) begin failures++; $display("[TB] FAIL st_force_we: got %0b expected 1", bus.oMemWe); end
        checks++; if (bus.oMemAddr !== 16'h1020) begin failures++; $display("[TB] FAIL st_force_addr: got %0h expected 1020", bus.oMemAddr); end
        checks++; if (bus.oMemWData !== palette[1]) begin failures++; $display("[TB] FAIL st_force_wdata: got %0h expected %0h", bus.oMemWData, palette[1]); end
        checks++; if (bus.oCpuStall !== 1'b1) begin failures++; $display("[TB] FAIL st_force_stall: got %0b expected 1", bus.oCpuStall); end
        nextCycle();
        settle();
        checks++; if (bus.oVgaValid !== 1'b0) begin failures++; $display("[TB] FAIL st_drop_valid: got %0b expected 0", bus.oVgaValid); end
        checks++; if (bus.oCpuStall !== 1'b0) begin failures++; $display("[TB] FAIL st_after_stall: got %0b expected 0", bus.oCpuStall); end
        checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL st_after_we: got %0b expected 0", bus.oMemWe); end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 8'd3, 8'd3);
        settle();
        checks++; if (bus.oCpuStall !== 1'b1) begin failures++; $display("[TB] FAIL st_fifth_accepted: got %0b expected 1", bus.oCpuStall); end
`ifdef VRAM_ARB_STATS_EN
        checks++; if (oStallCycles !== 16'd9) begin failures++; $display("[TB] FAIL st_stat_stalls: got %0d expected 9", oStallCycles); end
        checks++; if (oForcedWrites !== 8'd1) begin failures++; $display("[TB] FAIL st_stat_forced: got %0d expected 1", oForcedWrites); end
`endif
        nextCycle();
    endtask

    task automatic test_push_pop();
        logic [15:0]   expAddr [4];
        logic [CW-1:0] expCol [4];
        expAddr = '{16'h0301, 16'h0302, 16'h0404, 16'h0404};
        expCol  = '{COLOR_BLUE, COLOR_CYAN, COLOR_YELLOW, COLOR_WHITE};
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, expAddr[i][15:8], expAddr[i][7:0], expCol[i], 1, 0, 0);
            nextCycle();
        end
        applyStimulus(1, expAddr[3][15:8], expAddr[3][7:0], expCol[3], 0, 0, 0);
        settle();
        checks++; if (bus.oCpuStall !== 1'b0) begin failures++; $display("[TB] FAIL pp_stall: got %0b expected 0", bus.oCpuStall); end
        checks++; if (bus.oMemWe !== 1'b1 || bus.oMemAddr !== expAddr[0]) begin failures++; $display("[TB] FAIL pp_first: got we=%0b addr=%0h expected we=1 addr=%0h", bus.oMemWe, bus.oMemAddr, expAddr[0]); end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j < 4; j++) begin
            settle();
            checks++; if (bus.oMemWe !== 1'b1 || bus.oMemAddr !== expAddr[j] || bus.oMemWData !== expCol[j]) begin
                failures++; $display("[TB] FAIL pp_order%0d: got we=%0b addr=%0h data=%0h expected we=1 addr=%0h data=%0h", j, bus.oMemWe, bus.oMemAddr, bus.oMemWData, expAddr[j], expCol[j]);
            end
            nextCycle();
        end
        settle();
        checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL pp_drained: got %0b expected 0", bus.oMemWe); end
        nextCycle();
    endtask

    task automatic test_reset_flush();
        doReset();
        applyStimulus(1, 8'h05, 8'h06, COLOR_MAGENTA, 1, 0, 0);
        nextCycle();
        applyStimulus(1, 8'h05, 8'h07, COLOR_RED, 1, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        nextCycle();
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL rf_reset_we: got %0b expected 0", bus.oMemWe); end
        checks++; if (bus.oVgaValid !== 1'b1) begin failures++; $display("[TB] FAIL rf_reset_valid: got %0b expected 1", bus.oVgaValid); end
        nextCycle();
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (bus.oMemWe !== 1'b0) begin failures++; $display("[TB] FAIL rf_we%0d: got %0b expected 0", k, bus.oMemWe); end
            checks++; if (bus.oCpuStall !== 1'b0) begin failures++; $display("[TB] FAIL rf_stall%0d: got %0b expected 0", k, bus.oCpuStall); end
            checks++; if (bus.oVgaValid !== 1'b0) begin failures++; $display("[TB] FAIL rf_valid%0d: got %0b expected 0", k, bus.oVgaValid); end
            nextCycle();
        end
    endtask

    task automatic test_random();
        wrEntry_t      q[$];
        wrEntry_t      ent;
        int            blockedRun = 0;
        bit            forceNow = 0;
        bit            forceNext;
        bit            prevRead = 0;
        logic [15:0]   prevAddr = '0;
        bit            rstNow, wr, rd, rdG, wrG, expStall;
        logic [7:0]    row, col, vRow, vCol;
        logic [CW-1:0] color;
        logic [15:0]   expAddr;
        logic [CW-1:0] expWData, expData;
        doReset();
        for (int a = 0; a < 65536; a++) refRam[a] = envRam[a];
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rstNow = ($urandom_range(0, 99) < 2);
            wr     = ($urandom_range(0, 99) < 70);
            rd     = ($urandom_range(0, 99) < 75);
            row    = 8'($urandom_range(0, 3));
            col    = 8'($urandom_range(0, 3));
            vRow   = 8'($urandom_range(0, 3));
            vCol   = 8'($urandom_range(0, 3));
            color  = palette[$urandom_range(0, 7)];
            Reset  = rstNow;
            applyStimulus(wr, row, col, color, rd, vRow, vCol);
            settle();

            expStall = (q.size() == DEPTH);
            rdG = 0;
            wrG = 0;
            if (!rstNow) begin
                if (forceNow) wrG = (q.size() > 0);
                else if (rd) rdG = 1;
                else wrG = (q.size() > 0);
            end
            expAddr  = wrG ? q[0].addr : (rdG ? {vRow, vCol} : 16'h0000);
            expWData = wrG ? q[0].color : '0;
            expData  = prevRead ? refRam[prevAddr] : '0;

            checks++; if (bus.oCpuStall !== expStall) begin failures++; $display("[TB] FAIL rnd_stall@%0d: got %0b expected %0b", cyc, bus.oCpuStall, expStall); end
            checks++; if (bus.oMemWe !== wrG) begin failures++; $display("[TB] FAIL rnd_we@%0d: got %0b expected %0b", cyc, bus.oMemWe, wrG); end
            checks++; if (bus.oMemAddr !== expAddr) begin failures++; $display("[TB] FAIL rnd_addr@%0d: got %0h expected %0h", cyc, bus.oMemAddr, expAddr); end
            if (!rdG) begin
                checks++; if (bus.oMemWData !== expWData) begin failures++; $display("[TB] FAIL rnd_wdata@%0d: got %0h expected %0h", cyc, bus.oMemWData, expWData); end
            end
            checks++; if (bus.oVgaValid !== prevRead) begin failures++; $display("[TB] FAIL rnd_valid@%0d: got %0b expected %0b", cyc, bus.oVgaValid, prevRead); end
            checks++; if (bus.oVgaData !== expData) begin failures++; $display("[TB] FAIL rnd_data@%0d: got %0h expected %0h", cyc, bus.oVgaData, expData); end

            if (wrG) begin
                refRam[q[0].addr] = q[0].color;
                void'(q.pop_front());
            end
            if (rstNow) begin
                q.delete();
                blockedRun = 0;
                forceNext  = 0;
                prevRead   = 0;
            end else begin
                if (wr && !expStall) begin
                    ent.addr  = {row, col};
                    ent.color = color;
                    q.push_back(ent);
                end
                forceNext = 0;
                if (forceNow) begin
                    blockedRun = 0;
                end else if (expStall && wr && rd) begin
                    blockedRun++;
                    if (blockedRun == LIMIT) begin
                        forceNext  = 1;
                        blockedRun = 0;
                    end
                end else begin
                    blockedRun = 0;
                end
                prevRead = rdG;
                prevAddr = {vRow, vCol};
            end
            forceNow = forceNext;
            nextCycle();
        end
        Reset = 1'b0;
    endtask

    initial begin
        palette = '{COLOR_BLACK, COLOR_BLUE, COLOR_GREEN, COLOR_CYAN,
                    COLOR_RED, COLOR_MAGENTA, COLOR_YELLOW, COLOR_WHITE};
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_single_write();
        test_read_latency();
        test_starvation();
        test_push_pop();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
